m_bb: RTL and testbench

- 2-bit × 2-bit multiplier brick for the MFU; bricks are composed into wider fused multipliers.
- Each operand is independently treated as signed or unsigned under control of sel.
- Produces a 4-bit product, registered on the clock, with an enable that zero-gates the output.

---
 rtl/m_bb.sv | 56 +++++
 tb/tb_m_bb.sv | 138 +++++++++++++
 2 files changed

// File: rtl/m_bb.sv
// 2x2 multiplier brick with per-operand signedness, registered and enable-gated output.
// Optional macro MBB_VALID_OUT_EN adds a registered p_valid output.
module m_bb (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] sel,
    output logic [3:0] p
`ifdef MBB_VALID_OUT_EN
    ,
    output logic       p_valid
`endif
);

    localparam int unsigned OP_W   = 2;
    localparam int unsigned EXT_W  = OP_W + 1;
    localparam int unsigned FULL_W = 2 * EXT_W;
    localparam int unsigned PROD_W = 2 * OP_W;

    logic signed [EXT_W-1:0]  a_ext;
    logic signed [EXT_W-1:0]  b_ext;
    logic signed [FULL_W-1:0] full_c;
    logic        [PROD_W-1:0] product_c;

    // Sign bit of each extended operand is its MSB only when that operand is selected as signed.
    always_comb begin
        a_ext     = $signed({sel[1] & a[1], a});
        b_ext     = $signed({sel[0] & b[1], b});
        full_c    = FULL_W'(a_ext) * FULL_W'(b_ext);
        product_c = full_c[PROD_W-1:0];
    end

    // Disabled cycles drive zero so downstream adders see no contribution.
    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else if (en) begin
            p <= product_c;
        end else begin
            p <= '0;
        end
    end

`ifdef MBB_VALID_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
        end else begin
            p_valid <= en;
        end
    end
`endif

endmodule

// File: tb/tb_m_bb.sv
// Self-checking bench for m_bb: directed vector table, enable-gated sweep, reset sequences, random run.
module tb_m_bb;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] sel;
    logic [3:0] p;
`ifdef MBB_VALID_OUT_EN
    logic       p_valid;
`endif

    int n_cmp;
    int n_bad;

    m_bb dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a      (a),
        .b      (b),
        .sel    (sel),
        .p      (p)
`ifdef MBB_VALID_OUT_EN
        ,
        .p_valid(p_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] sel;
        logic [3:0] exp_p;
    } vec_t;

    vec_t vecs[9];

    function automatic int opval(input logic [1:0] v, input logic is_signed);
        int x;
        x = int'(v);
        if (is_signed && x >= 2) x = x - 4;
        return x;
    endfunction

    function automatic logic [3:0] model_p(input logic r, input logic e, input logic [1:0] av,
                                           input logic [1:0] bv, input logic [1:0] s);
        int prod;
        if (r || !e) return 4'd0;
        prod = opval(av, s[1]) * opval(bv, s[0]);
        return 4'((prod % 16 + 16) % 16);
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got p=%0d (%b) expected %0d (%b)", name, got, got, exp, exp);
        end
    endtask

    // Apply inputs, clock one edge, then check p against the model (and p_valid if present).
    task automatic step(input string name, input logic r, input logic e, input logic [1:0] av,
                        input logic [1:0] bv, input logic [1:0] s);
        rst = r; en = e; a = av; b = bv; sel = s;
        @(posedge clk);
        #1;
        check(name, p, model_p(r, e, av, bv, s));
`ifdef MBB_VALID_OUT_EN
        n_cmp++;
        if (p_valid !== (!r && e)) begin
            n_bad++;
            $display("FAIL %s p_valid: got %b expected %b", name, p_valid, (!r && e));
        end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; en = 1'b0; a = '0; b = '0; sel = '0;

        vecs[0] = '{1'b1, 2'd3, 2'd3, 2'b00, 4'b1001};
        vecs[1] = '{1'b1, 2'd2, 2'd1, 2'b00, 4'd2};
        vecs[2] = '{1'b1, 2'd0, 2'd3, 2'b00, 4'd0};
        vecs[3] = '{1'b1, 2'd2, 2'd2, 2'b11, 4'b0100};
        vecs[4] = '{1'b1, 2'd3, 2'd2, 2'b11, 4'b0010};
        vecs[5] = '{1'b1, 2'd1, 2'd3, 2'b11, 4'b1111};
        vecs[6] = '{1'b1, 2'd2, 2'd3, 2'b10, 4'b1010};
        vecs[7] = '{1'b1, 2'd3, 2'd2, 2'b01, 4'b1010};
        vecs[8] = '{1'b1, 2'd1, 2'd3, 2'b01, 4'b1111};

        // Reset held two cycles with live operands.
        step("reset0", 1'b1, 1'b1, 2'd3, 2'd3, 2'b00);
        check("reset0_const", p, 4'd0);
        step("reset1", 1'b1, 1'b1, 2'd3, 2'd3, 2'b00);
        step("first_after_reset", 1'b0, 1'b1, 2'd2, 2'd1, 2'b00);

        // Directed table: expected values written by hand.
        for (int i = 0; i < 9; i++) begin
            rst = 1'b0; en = vecs[i].en; a = vecs[i].a; b = vecs[i].b; sel = vecs[i].sel;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), p, vecs[i].exp_p);
        end

        // Alternating enable sweep over all sel/a/b combinations.
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 16; k++) begin
                step($sformatf("sweep_on s%0d k%0d", s, k), 1'b0, 1'b1, 2'(k >> 2), 2'(k), 2'(s));
                step($sformatf("sweep_off s%0d k%0d", s, k), 1'b0, 1'b0, 2'(k >> 2), 2'(k), 2'(s));
            end
        end

        // Reset mid-stream overrides enable; next enabled edge is valid again.
        step("mid_pre", 1'b0, 1'b1, 2'd3, 2'd3, 2'b00);
        step("mid_rst", 1'b1, 1'b1, 2'd3, 2'd3, 2'b00);
        check("mid_rst_const", p, 4'd0);
        step("mid_post", 1'b0, 1'b1, 2'd3, 2'd3, 2'b00);
        check("mid_post_const", p, 4'd9);

        // Random stimulus against the arithmetic model.
        for (int i = 0; i < 300; i++) begin
            step($sformatf("rand%0d", i), ($urandom_range(0, 15) == 0), 1'($urandom),
                 2'($urandom), 2'($urandom), 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
